// File: rtl/lpif_tx_fifo.sv
// LPIF transmit FIFO: buffers link-layer beats toward the PHY and checks
// TLP/DLLP framing on every accepted beat.
module lpif_tx_fifo #(
  parameter  int LPIF_BUS_WIDTH = 32,
  parameter  int DEPTH          = 4,
  localparam int NB             = LPIF_BUS_WIDTH / 8,
  localparam int AW             = $clog2(DEPTH) + 1
) (
  input  logic                      lclk,
  input  logic                      reset,
  input  logic                      lp_irdy,
  input  logic [LPIF_BUS_WIDTH-1:0] lp_data,
  input  logic [NB-1:0]             lp_valid,
  input  logic [NB-1:0]             lp_tlp_start,
  input  logic [NB-1:0]             lp_tlp_end,
  input  logic [NB-1:0]             lp_dllp_start,
  input  logic [NB-1:0]             lp_dllp_end,
  input  logic [NB-1:0]             lp_tlpedb,
  output logic                      pl_trdy,
  input  logic [3:0]                pl_state_sts,
  input  logic                      lp_force_detect,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [LPIF_BUS_WIDTH-1:0] tx_data,
  output logic [NB-1:0]             tx_byte_valid,
  output logic [NB-1:0]             tx_tlp_start,
  output logic [NB-1:0]             tx_tlp_end,
  output logic [NB-1:0]             tx_dllp_start,
  output logic [NB-1:0]             tx_dllp_end,
  output logic [NB-1:0]             tx_tlpedb,
  output logic [AW-1:0]             fill_level,
  output logic                      frame_err,
  output logic [7:0]                err_count
);

  localparam int PW = AW - 1;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;
  localparam int EW = LPIF_BUS_WIDTH + 6 * NB;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_TLP  = 2'd1,
    IN_DLLP = 2'd2
  } state_t;

  function automatic logic multi_hot(input logic [NB-1:0] v);
    return (v & (v - NB'(1))) != '0;
  endfunction

  // Lowest set lane; only meaningful once multi_hot has been ruled out.
  function automatic logic [LW-1:0] lane_idx(input logic [NB-1:0] v);
    logic [LW-1:0] idx;
    idx = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (v[i]) idx = LW'(i);
    end
    return idx;
  endfunction

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [AW-1:0] count_reg;
  state_t        state_reg;
  state_t        state_next;
  logic          frame_err_reg;
  logic [7:0]    err_count_reg;

  logic active;
  logic flush;
  logic push;
  logic pop;

  assign active   = (pl_state_sts == 4'h1);
  assign flush    = lp_force_detect;
  assign pl_trdy  = ~reset & active & ~flush & (count_reg < AW'(DEPTH));
  assign tx_valid = ~reset & active & ~flush & (count_reg != '0);
  assign push     = lp_irdy & pl_trdy;
  assign pop      = tx_valid & tx_ready;

  // Head is read straight from the array so a popped pointer shows the next
  // entry without a bubble; tx_valid only rises a cycle after the write.
  assign {tx_data, tx_byte_valid, tx_tlp_start, tx_tlp_end,
          tx_dllp_start, tx_dllp_end, tx_tlpedb} = tx_valid ? mem[rd_ptr_reg] : '0;

  assign fill_level = reset ? '0 : count_reg;
  assign frame_err  = ~reset & frame_err_reg;
  assign err_count  = reset ? 8'd0 : err_count_reg;

  always_ff @(posedge lclk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {lp_data, lp_valid, lp_tlp_start, lp_tlp_end,
                          lp_dllp_start, lp_dllp_end, lp_tlpedb};
    end
  end

  logic          ts_any, te_any, ds_any, de_any, edb_any;
  logic [LW-1:0] ts_idx, te_idx, ds_idx, de_idx;
  logic [LW-1:0] start_idx;
  logic          open_end_any;
  logic [LW-1:0] open_end_idx;
  logic          err_multi, err_lane, err_empty, err_edb, err_mix;
  logic          err_start, err_end_tlp, err_end_dllp;
  logic          beat_err;

  assign ts_any  = |lp_tlp_start;
  assign te_any  = |lp_tlp_end;
  assign ds_any  = |lp_dllp_start;
  assign de_any  = |lp_dllp_end;
  assign edb_any = |lp_tlpedb;
  assign ts_idx  = lane_idx(lp_tlp_start);
  assign te_idx  = lane_idx(lp_tlp_end);
  assign ds_idx  = lane_idx(lp_dllp_start);
  assign de_idx  = lane_idx(lp_dllp_end);

  assign start_idx    = ts_any ? ts_idx : ds_idx;
  assign open_end_any = (state_reg == IN_TLP) ? te_any : de_any;
  assign open_end_idx = (state_reg == IN_TLP) ? te_idx : de_idx;

  assign err_multi = multi_hot(lp_tlp_start) | multi_hot(lp_tlp_end) |
                     multi_hot(lp_dllp_start) | multi_hot(lp_dllp_end);
  assign err_lane  = |((lp_tlp_start | lp_tlp_end | lp_dllp_start |
                        lp_dllp_end | lp_tlpedb) & ~lp_valid);
  assign err_empty = (lp_valid == '0);
  assign err_edb   = |(lp_tlpedb & ~lp_tlp_end);
  assign err_mix   = (ts_any | te_any | edb_any) & (ds_any | de_any);

  // A new start inside an open packet is legal only after that packet's end.
  assign err_start = (state_reg != IDLE) & (ts_any | ds_any) &
                     ~(open_end_any & (open_end_idx < start_idx));
  assign err_end_tlp  = te_any & ~((state_reg == IN_TLP) | (ts_any & (ts_idx <= te_idx)));
  assign err_end_dllp = de_any & ~((state_reg == IN_DLLP) | (ds_any & (ds_idx <= de_idx)));

  assign beat_err = err_multi | err_lane | err_empty | err_edb | err_mix |
                    err_start | err_end_tlp | err_end_dllp;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (ts_any)
          state_next = (te_any && te_idx >= ts_idx) ? IDLE : IN_TLP;
        else if (ds_any)
          state_next = (de_any && de_idx >= ds_idx) ? IDLE : IN_DLLP;
      end
      IN_TLP: begin
        if (te_any)
          state_next = (ts_any && ts_idx > te_idx) ? IN_TLP :
                       (ds_any && ds_idx > te_idx) ? IN_DLLP : IDLE;
      end
      IN_DLLP: begin
        if (de_any)
          state_next = (ds_any && ds_idx > de_idx) ? IN_DLLP :
                       (ts_any && ts_idx > de_idx) ? IN_TLP : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge lclk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      state_reg     <= IDLE;
      frame_err_reg <= 1'b0;
      err_count_reg <= 8'd0;
    end else if (flush) begin
      // Error history survives a flush; everything else restarts.
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      state_reg     <= IDLE;
      frame_err_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + AW'(1);
        2'b01:   count_reg <= count_reg - AW'(1);
        default: count_reg <= count_reg;
      endcase
      frame_err_reg <= push & beat_err;
      if (push) begin
        state_reg <= beat_err ? IDLE : state_next;
        if (beat_err && err_count_reg != 8'hFF)
          err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

endmodule
